// File: rtl/cache_way_pkg.sv
// Shared types and address-field helpers for the writeback cache way.
package cache_way_pkg;

   typedef enum logic [1:0] {IDLE, FILL, EVICT, DONE} state_t;

   function automatic logic [31:0] set_of(input logic [31:0] a, input int unsigned setbits,
                                          input int unsigned blockoffset);
      return (a >> (blockoffset + 32'd2)) & ((32'd1 << setbits) - 32'd1);
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a, input int unsigned blockoffset);
      return (a >> 2) & ((32'd1 << blockoffset) - 32'd1);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a, input int unsigned setbits,
                                          input int unsigned blockoffset);
      return a >> (setbits + blockoffset + 32'd2);
   endfunction

endpackage

// File: rtl/writeback_cache_way_seq_bank.sv
// Word storage for one way: byte-masked synchronous write, two combinational reads.
// With CACHE_WAY_PARITY_EN defined, keeps one even-parity bit per byte and flags mismatches.
module cache_word_bank #(
   parameter  int unsigned depth = 1024,
   localparam int unsigned abits = $clog2(depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       mask,
   input  logic [abits-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [abits-1:0] raddr0,
   output logic [31:0]      rdata0,
   output logic             perr0,
   input  logic [abits-1:0] raddr1,
   output logic [31:0]      rdata1,
   output logic             perr1
);

   logic [31:0] mem [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

`ifdef CACHE_WAY_PARITY_EN
   logic [3:0] par [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) par[waddr][b] <= ^wdata[8*b +: 8];
         end
      end
   end

   // A byte is bad when its stored parity bit disagrees with its recomputed parity.
   function automatic logic parity_bad(input logic [31:0] d, input logic [3:0] p);
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 4; b++) bad = bad | ((^d[8*b +: 8]) ^ p[b]);
      return bad;
   endfunction

   assign perr0 = parity_bad(rdata0, par[raddr0]);
   assign perr1 = parity_bad(rdata1, par[raddr1]);
`else
   assign perr0 = 1'b0;
   assign perr1 = 1'b0;
`endif

endmodule

// File: rtl/writeback_cache_way_seq.sv
// One way of a writeback cache with an on-way fill/evict block sequencer.
// Optional per-byte parity enabled by defining CACHE_WAY_PARITY_EN.
module writeback_cache_way_seq
   import cache_way_pkg::*;
#(
   parameter  int unsigned lines       = 256,
   parameter  int unsigned blocksize   = 4,
   localparam int unsigned setbits     = $clog2(lines),
   localparam int unsigned blockoffset = $clog2(blocksize),
   localparam int unsigned tagbits     = 30 - setbits - blockoffset
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        A,
   input  logic               WE,
   input  logic [31:0]        WD,
   input  logic [3:0]         ByteMask,
   input  logic               FillStart,
   input  logic [31:0]        FillData,
   input  logic               FillValid,
   output logic               FillReady,
   input  logic               EvictStart,
   output logic [31:0]        EvictData,
   output logic [31:0]        EvictAddr,
   output logic               EvictValid,
   input  logic               EvictReady,
   output logic [31:0]        RD,
   output logic [tagbits-1:0] RTag,
   output logic               RV,
   output logic               Dirty,
   output logic               Hit,
   output logic               Busy,
   output logic               Done,
   output logic               ParityErr
);

   state_t state, state_nx;

   logic [blockoffset-1:0] cnt;
   logic [setbits-1:0]     bset;
   logic [tagbits-1:0]     btag;
   logic [tagbits-1:0]     tags [lines];
   logic [lines-1:0]       v, dirty;

   logic [setbits-1:0]     aset;
   logic [blockoffset-1:0] aword;
   logic [tagbits-1:0]     atag;
   logic                   last;

   logic        bank_we;
   logic [3:0]  bank_mask;
   logic [setbits+blockoffset-1:0] bank_waddr;
   logic [31:0] bank_wdata;
   logic        perr_rd, perr_ev;

   assign aset  = setbits'(set_of(A, setbits, blockoffset));
   assign aword = blockoffset'(word_of(A, blockoffset));
   assign atag  = tagbits'(tag_of(A, setbits, blockoffset));
   assign last  = (cnt == blockoffset'(blocksize - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and handshake outputs; evict wins over a simultaneous fill.
   always_comb begin
      state_nx   = state;
      FillReady  = 1'b0;
      EvictValid = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            if (EvictStart)     state_nx = (v[aset] && dirty[aset]) ? EVICT : DONE;
            else if (FillStart) state_nx = FILL;
         end
         FILL: begin
            Busy      = 1'b1;
            FillReady = 1'b1;
            if (FillValid && last) state_nx = DONE;
         end
         EVICT: begin
            Busy       = 1'b1;
            EvictValid = 1'b1;
            if (EvictReady && last) state_nx = DONE;
         end
         DONE: begin
            Busy     = 1'b1;
            Done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Burst bookkeeping and per-set valid/dirty state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         bset  <= '0;
         btag  <= '0;
         v     <= '0;
         dirty <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (EvictStart) begin
                  bset <= aset;
                  cnt  <= '0;
               end else if (FillStart) begin
                  bset    <= aset;
                  btag    <= atag;
                  v[aset] <= 1'b0;
                  cnt     <= '0;
               end else if (WE) begin
                  dirty[aset] <= 1'b1;
               end
            end
            FILL: begin
               if (FillValid) begin
                  cnt <= cnt + blockoffset'(1);
                  if (last) begin
                     v[bset]     <= 1'b1;
                     dirty[bset] <= 1'b0;
                  end
               end
            end
            EVICT: begin
               if (EvictReady) begin
                  cnt <= cnt + blockoffset'(1);
                  if (last) dirty[bset] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && state == FILL && FillValid && last) tags[bset] <= btag;
   end

   // Bank write port: fill words in FILL, CPU byte writes in a quiet IDLE cycle.
   always_comb begin
      bank_we    = 1'b0;
      bank_mask  = ByteMask;
      bank_waddr = {aset, aword};
      bank_wdata = WD;
      if (state == FILL) begin
         bank_we    = FillValid;
         bank_mask  = 4'hF;
         bank_waddr = {bset, cnt};
         bank_wdata = FillData;
      end else if (state == IDLE) begin
         bank_we = WE && !EvictStart && !FillStart;
      end
      if (reset) bank_we = 1'b0;
   end

   cache_word_bank #(.depth(lines * blocksize)) u_bank (
      .clk    (clk),
      .we     (bank_we),
      .mask   (bank_mask),
      .waddr  (bank_waddr),
      .wdata  (bank_wdata),
      .raddr0 ({aset, aword}),
      .rdata0 (RD),
      .perr0  (perr_rd),
      .raddr1 ({bset, cnt}),
      .rdata1 (EvictData),
      .perr1  (perr_ev)
   );

   assign RTag      = tags[aset];
   assign RV        = v[aset];
   assign Dirty     = dirty[aset];
   assign Hit       = RV && (RTag == atag);
   assign EvictAddr = {tags[bset], bset, cnt, 2'b00};
   assign ParityErr = perr_rd || (state == EVICT && perr_ev);

endmodule

// File: tb/tb_writeback_cache_way_seq.sv
// Randomized self-checking bench for writeback_cache_way_seq (lines=16, blocksize=4).
module tb_writeback_cache_way_seq;

   localparam int unsigned LINES = 16;
   localparam int unsigned BS    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, WD, FillData, EvictData, EvictAddr, RD;
   logic        WE, FillStart, FillValid, FillReady, EvictStart, EvictValid, EvictReady;
   logic [3:0]  ByteMask;
   logic [23:0] RTag;
   logic        RV, Dirty, Hit, Busy, Done, ParityErr;

   always #5 clk = ~clk;

   writeback_cache_way_seq #(.lines(LINES), .blocksize(BS)) dut (
      .clk(clk), .reset(reset), .A(A), .WE(WE), .WD(WD), .ByteMask(ByteMask),
      .FillStart(FillStart), .FillData(FillData), .FillValid(FillValid), .FillReady(FillReady),
      .EvictStart(EvictStart), .EvictData(EvictData), .EvictAddr(EvictAddr),
      .EvictValid(EvictValid), .EvictReady(EvictReady), .RD(RD), .RTag(RTag), .RV(RV),
      .Dirty(Dirty), .Hit(Hit), .Busy(Busy), .Done(Done), .ParityErr(ParityErr)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: contents of each set as the cache rules define them.
   logic [31:0] m_data  [LINES][BS];
   bit          m_known [LINES][BS];
   logic [23:0] m_tag   [LINES];
   bit          m_v     [LINES];
   bit          m_d     [LINES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned set_a(input logic [31:0] a);
      return (a >> 4) % LINES;
   endfunction
   function automatic int unsigned word_a(input logic [31:0] a);
      return (a >> 2) % BS;
   endfunction
   function automatic logic [23:0] tag_a(input logic [31:0] a);
      return 24'(a >> 8);
   endfunction
   function automatic logic [31:0] mk_addr(input logic [31:0] t, input int unsigned s,
                                           input int unsigned w);
      return (t << 8) | (s << 4) | (w << 2);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_read(input logic [31:0] a);
      int unsigned s = set_a(a);
      int unsigned w = word_a(a);
      A = a;
      #1;
      check("RV", RV, m_v[s]);
      check("Dirty", Dirty, m_d[s]);
      check("Hit", Hit, m_v[s] && (m_tag[s] == tag_a(a)));
      if (m_v[s]) check("RTag", RTag, m_tag[s]);
      if (m_known[s][w]) check("RD", RD, m_data[s][w]);
   endtask

   task automatic do_fill(input logic [31:0] a, input logic [31:0] d [BS], input int gap_word,
                          input int gap_len, input bit noise);
      int unsigned s = set_a(a);
      A = a; FillStart = 1'b1; WE = noise; WD = $urandom; ByteMask = 4'hF;
      step();
      FillStart = 1'b0; WE = 1'b0;
      check("fill_busy", Busy, 1);
      check("fill_ready", FillReady, 1);
      m_v[s] = 1'b0;
      for (int i = 0; i < int'(BS); i++) begin
         if (i == gap_word) begin
            for (int g = 0; g < gap_len; g++) begin
               FillValid = 1'b0; WE = noise; A = $urandom; WD = $urandom;
               #1 check("fill_wait_done", Done, 0);
               step();
            end
         end
         FillValid = 1'b1; FillData = d[i]; WE = 1'b0;
         step();
      end
      FillValid = 1'b0;
      check("fill_done", Done, 1);
      m_tag[s] = tag_a(a); m_v[s] = 1'b1; m_d[s] = 1'b0;
      for (int i = 0; i < int'(BS); i++) begin
         m_data[s][i] = d[i]; m_known[s][i] = 1'b1;
      end
      // Start requests during DONE must be ignored.
      if (noise) begin
         EvictStart = 1'b1; FillStart = 1'b1;
      end
      step();
      EvictStart = 1'b0; FillStart = 1'b0;
      check("fill_done_pulse", Done, 0);
      check("fill_idle", Busy, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
      int unsigned s = set_a(a);
      int unsigned w = word_a(a);
      A = a; WD = wd; ByteMask = m; WE = 1'b1;
      step();
      WE = 1'b0;
      for (int b = 0; b < 4; b++) if (m[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
      m_known[s][w] = m_known[s][w] || (m == 4'hF);
      m_d[s] = 1'b1;
   endtask

   task automatic do_evict(input logic [31:0] a, input bit with_fill, input int stall_word,
                           input int stall_len);
      int unsigned s = set_a(a);
      bit go = m_v[s] && m_d[s];
      int stalls;
      A = a; EvictStart = 1'b1; FillStart = with_fill; EvictReady = 1'b0;
      WE = 1'($urandom_range(0, 1)); WD = $urandom; ByteMask = 4'($urandom);
      step();
      EvictStart = 1'b0; FillStart = 1'b0; WE = 1'b0;
      if (go) begin
         for (int i = 0; i < int'(BS); i++) begin
            stalls = (i == stall_word) ? stall_len : 0;
            for (int k = 0; k <= stalls; k++) begin
               EvictReady = (k == stalls); A = $urandom;
               #1;
               check("ev_valid", EvictValid, 1);
               check("ev_addr", EvictAddr, mk_addr(32'(m_tag[s]), s, i));
               check("ev_data", EvictData, m_data[s][i]);
               check("ev_fready", FillReady, 0);
               step();
            end
         end
         EvictReady = 1'b0;
         m_d[s] = 1'b0;
      end
      check("ev_done", Done, 1);
      check("ev_valid_off", EvictValid, 0);
      step();
      check("ev_done_pulse", Done, 0);
      check("ev_idle", Busy, 0);
   endtask

   logic [31:0] dd [BS];
   logic [31:0] ra;
   int unsigned rs;
   logic [3:0]  pbits;

   initial begin
      reset = 1'b1; A = '0; WE = 1'b0; WD = '0; ByteMask = '0; FillStart = 1'b0;
      FillData = '0; FillValid = 1'b0; EvictStart = 1'b0; EvictReady = 1'b0;
      for (int s = 0; s < int'(LINES); s++) begin
         m_v[s] = 1'b0; m_d[s] = 1'b0;
         for (int w = 0; w < int'(BS); w++) m_known[s][w] = 1'b0;
      end
      step(); step();
      reset = 1'b0;
      for (int s = 0; s < int'(LINES); s++) begin
         check_read(mk_addr(32'h12, s, 0));
         check("rst_busy", Busy, 0);
         check("rst_done", Done, 0);
         check("rst_fready", FillReady, 0);
         check("rst_evalid", EvictValid, 0);
`ifndef CACHE_WAY_PARITY_EN
         check("rst_perr", ParityErr, 0);
`endif
      end

      // Directed fill with a two-cycle FillValid gap.
      dd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      do_fill(32'h1230, dd, 2, 2, 1'b0);
      check_read(32'h1234);
      check("tp_rd", RD, 32'hA1);
      check("tp_rtag", RTag, 32'h12);
      check("tp_hit", Hit, 1);

      do_write(32'h1238, 32'hFFFF_FFFF, 4'b0010);
      check_read(32'h1238);
      check("tp_bytewr", RD, 32'h0000_FFA2);
      check("tp_dirty", Dirty, 1);

      do_evict(32'h1230, 1'b0, 1, 3);
      check_read(32'h1230);
      check("tp_ev_rv", RV, 1);

      do_evict(32'h1230, 1'b0, 0, 0);
      do_evict(32'h1230, 1'b1, 0, 0);
      check_read(32'h1230);
      check("tp_coll_rv", RV, 1);

      // Randomized mix of operations.
      for (int it = 0; it < 80; it++) begin
         rs = $urandom_range(0, LINES - 1);
         ra = mk_addr(m_v[rs] && $urandom_range(0, 3) != 0 ? 32'(m_tag[rs]) : 32'($urandom_range(0, 3)),
                      rs, $urandom_range(0, BS - 1));
         case ($urandom_range(0, 4))
            0: begin
               for (int i = 0; i < int'(BS); i++) dd[i] = $urandom;
               do_fill(mk_addr($urandom_range(0, 3), rs, 0), dd, $urandom_range(0, BS - 1),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
            1: do_write(ra, $urandom, 4'($urandom));
            2: do_write(ra, $urandom, 4'hF);
            3: do_evict(ra, 1'($urandom_range(0, 1)), $urandom_range(0, BS - 1),
                        $urandom_range(0, 3));
            default: step();
         endcase
         check_read(ra);
         check_read(mk_addr($urandom, $urandom_range(0, LINES - 1), $urandom_range(0, BS - 1)));
      end

      // Reset in the middle of a fill of set 3.
      A = 32'h5630; FillStart = 1'b1;
      step();
      FillStart = 1'b0;
      for (int i = 0; i < 2; i++) begin
         FillValid = 1'b1; FillData = 32'hC0 + 32'(i);
         step();
      end
      FillValid = 1'b0;
      m_data[3][0] = 32'hC0; m_data[3][1] = 32'hC1;
      m_known[3][0] = 1'b1; m_known[3][1] = 1'b1;
      reset = 1'b1;
      step();
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_done", Done, 0);
      check("mid_rst_fready", FillReady, 0);
      for (int s = 0; s < int'(LINES); s++) begin
         m_v[s] = 1'b0; m_d[s] = 1'b0;
      end
      reset = 1'b0;
      step();
      check("post_rst_done", Done, 0);
      check("post_rst_busy", Busy, 0);
      check_read(32'h5630);
      check_read(32'h5634);

`ifdef CACHE_WAY_PARITY_EN
      A = 32'h5630;
      #1 check("par_clean", ParityErr, 0);
      pbits = dut.u_bank.par[12];
      force dut.u_bank.par[12] = pbits ^ 4'b0001;
      #1 check("par_flip", ParityErr, 1);
      release dut.u_bank.par[12];
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_cache_way_seq.md
Name: writeback_cache_way_seq

Overview:
- One way of a set-associative writeback data cache, generalised in line count and block size.
- Adds an on-way block sequencer that streams a whole block in (line fill) or out (eviction) over valid/ready handshakes, one word per transfer.
- Sits under the cache controller: the controller issues FillStart/EvictStart and the way runs the burst autonomously.

Parameters:
- lines, 256, number of sets; power of 2, at least 2.
- blocksize, 4, words per block; power of 2, at least 2.
- Derived localparams: setbits=$clog2(lines), blockoffset=$clog2(blocksize), tagbits=30-setbits-blockoffset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- A  in  32  address; word=A[blockoffset+1:2], set=A[blockoffset+setbits+1:blockoffset+2], tag=A[31:32-tagbits].
- WE  in  1  CPU write of word A; honoured only in IDLE.
- WD  in  32  CPU write data.
- ByteMask  in  4  byte enables for a CPU write.
- FillStart  in  1  begin fill of block A.
- FillData  in  32  fill word.
- FillValid  in  1  FillData valid.
- FillReady  out  1  way accepts FillData.
- EvictStart  in  1  begin eviction of the line at set(A).
- EvictData  out  32  evicted word.
- EvictAddr  out  32  {stored tag, set, word count, 2'b00}.
- EvictValid  out  1  EvictData valid.
- EvictReady  in  1  consumer accepts EvictData.
- RD  out  32  word(A) of set(A), combinational.
- RTag  out  tagbits  stored tag of set(A).
- RV  out  1  valid bit of set(A).
- Dirty  out  1  dirty bit of set(A).
- Hit  out  1  RV and RTag==tag(A).
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse when a fill or evict completes.
- ParityErr  out  1  see Optional Feature.

Behaviour:
- States: IDLE, FILL, EVICT, DONE.
- Reset:
  - State goes to IDLE; word counter to 0; all v and DirtyBits to 0.
  - Done, FillReady, EvictValid, Busy and ParityErr are 0.
  - The data array and tag array are not reset.
- IDLE reads:
  - RD, RTag, RV, Dirty and Hit are combinational from A.
  - WE with ByteMask writes the enabled bytes of word(A) on the clock edge and sets Dirty[set]=1; tag and v are unchanged.
- IDLE starts:
  - EvictStart: latch set(A); counter=0.
    - If the line is valid and dirty, go to EVICT.
    - Otherwise go straight to DONE; no EvictValid is issued.
  - FillStart (without EvictStart): latch set and tag; v[set]=0 the same edge; counter=0; go to FILL.
  - Both asserted in the same cycle: the evict is taken and the fill is dropped; the controller must re-assert FillStart.
  - WE is ignored in the start cycle and whenever Busy=1.
- FILL:
  - FillReady=1.
  - Each cycle with FillValid=1, write FillData (full mask) to word[counter] and increment the counter.
  - On the last word (counter==blocksize-1): write tag, set v=1 and Dirty=0; go to DONE.
  - FillValid low inserts wait cycles with no write.
- EVICT:
  - EvictValid=1; EvictData=word[counter]; EvictAddr as defined above.
  - Data and address are held stable while EvictReady=0.
  - On EvictReady=1, increment the counter. On the last accepted word, set Dirty=0 (v unchanged) and go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. A start request seen in DONE is ignored.
- Counter: blockoffset bits wide; wraps only via the state exit and never past blocksize-1.
- Reset mid-burst:
  - Returns to IDLE immediately and discards the burst.
  - v of the target set ends at 0 (cleared by reset); no Done pulse.

Optional Feature:
- Macro CACHE_WAY_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte, written with each byte write (CPU or fill).
  - ParityErr is asserted combinationally when RD, or EvictData in EVICT, has any byte whose parity mismatches.
  - Errors are flagged only; data is not corrected.
- When undefined: no parity storage and ParityErr is tied to 0.

Decomposition:
- Package cache_way_pkg holds:
  - the state enum typedef (IDLE, FILL, EVICT, DONE);
  - helper functions set_of, word_of and tag_of, parametrised by setbits and blockoffset.
- One sub-module, cache_word_bank:
  - depth lines*blocksize, 32-bit, byte-masked synchronous write, combinational read;
  - holds parity bits under the macro;
  - indexed {set, word}.

Test Plan:
- Reset: assert reset 2 cycles, then sweep A over all sets -> RV=0, Dirty=0, Hit=0, Busy=0, Done=0.
- Fill (lines=16, blocksize=4): FillStart at A=0x1230, then words 0xA0..0xA3 with FillValid low for 2 cycles mid-burst -> Done one cycle after 0xA3; A=0x1234 gives RD=0xA1, Hit=1, Dirty=0, RTag=0x000012.
- Byte write: WE at A=0x1238, WD=0xFFFFFFFF, ByteMask=4'b0010 -> RD=0x0000FFA2, Dirty=1, Hit=1.
- Evict with backpressure: EvictStart at A=0x1230 with EvictReady low 3 cycles on word 1 -> outputs (0x1230,0xA0), (0x1234,0xA1 held stable), (0x1238,0xFFA2), (0x123C,0xA3); then Done, Dirty=0, RV=1.
- Clean evict and collision: EvictStart on a clean line -> Done the next cycle, EvictValid never 1; FillStart with EvictStart together -> only the evict runs.
- Reset mid-fill after 2 words -> Busy=0, RV of set 3 = 0, no Done. Under CACHE_WAY_PARITY_EN, flip a stored parity bit via force -> ParityErr=1 when that word is read.
